// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and output register for the common data bus.
// Grants at most one functional unit per cycle (req_ready is combinational) and
// registers the winner's tag and payload onto the CDB one cycle later.
// Optional feature macro: CDB_ARB_PERF_EN adds saturating perf_grants and
// perf_conflicts counters; without it those ports and counters do not exist.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_rs1_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_rs2_data,
    output logic                      cdb_valid,
    output logic                      cdb_latch_en,
    output logic [NUM_REQ-1:0]        cdb_grant,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [DATA_W-1:0]         cdb_rs1_data,
    output logic [DATA_W-1:0]         cdb_rs2_data
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_grants,
    output logic [31:0]               perf_conflicts
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    // Round-robin state and registered CDB fields
    logic [PTR_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic               cdb_valid_q,  cdb_valid_d;
    logic [NUM_REQ-1:0] cdb_grant_q,  cdb_grant_d;
    logic [TAG_W-1:0]   cdb_tag_q,    cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q,   cdb_data_d;
    logic [DATA_W-1:0]  cdb_rs1_q,    cdb_rs1_d;
    logic [DATA_W-1:0]  cdb_rs2_q,    cdb_rs2_d;

    // Arbitration intermediates
    logic [PTR_W:0]     scan_sum_s;
    logic [PTR_W-1:0]   scan_idx_s;
    logic               grant_any_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic [DATA_W-1:0]  sel_rs1_s;
    logic [DATA_W-1:0]  sel_rs2_s;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_grants_q,    perf_grants_d;
    logic [31:0] perf_conflicts_q, perf_conflicts_d;

    // Population count of the request vector, used to detect contention
    function automatic logic [3:0] count_ones(input logic [NUM_REQ-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction
`endif

    // Scan from rr_ptr upward (mod NUM_REQ) and pick the first valid unit; reset and flush block all grants
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        scan_sum_s  = {(PTR_W+1){1'b0}};
        scan_idx_s  = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx_s = PTR_W'(scan_sum_s - (PTR_W+1)'(NUM_REQ));
            end else begin
                scan_idx_s = scan_sum_s[PTR_W-1:0];
            end
            if (!grant_any_s && req_valid[scan_idx_s] && !rst && !flush) begin
                grant_any_s = 1'b1;
                grant_idx_s = scan_idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot grant vector and AND-OR payload mux selected by it
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        sel_tag_s   = {TAG_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        sel_rs1_s   = {DATA_W{1'b0}};
        sel_rs2_s   = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i] = grant_any_s & (grant_idx_s == PTR_W'(i));
            sel_tag_s  = sel_tag_s  | (req_tag[i*TAG_W +: TAG_W]        & {TAG_W{req_ready_s[i]}});
            sel_data_s = sel_data_s | (req_data[i*DATA_W +: DATA_W]     & {DATA_W{req_ready_s[i]}});
            sel_rs1_s  = sel_rs1_s  | (req_rs1_data[i*DATA_W +: DATA_W] & {DATA_W{req_ready_s[i]}});
            sel_rs2_s  = sel_rs2_s  | (req_rs2_data[i*DATA_W +: DATA_W] & {DATA_W{req_ready_s[i]}});
        end
    end

    // Next-state: advance pointer past the winner and load the CDB; without a grant drop valid and hold payload
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_grant_d = {NUM_REQ{1'b0}};
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_rs1_d   = cdb_rs1_q;
        cdb_rs2_d   = cdb_rs2_q;
        if (grant_any_s) begin
            if (grant_idx_s == LAST_IDX) begin
                rr_ptr_d = {PTR_W{1'b0}};
            end else begin
                rr_ptr_d = grant_idx_s + PTR_W'(1);
            end
            cdb_valid_d = 1'b1;
            cdb_grant_d = req_ready_s;
            cdb_tag_d   = sel_tag_s;
            cdb_data_d  = sel_data_s;
            cdb_rs1_d   = sel_rs1_s;
            cdb_rs2_d   = sel_rs2_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

`ifdef CDB_ARB_PERF_EN
    // Saturating counters; flush does not clear them, only reset does
    always_comb begin
        perf_grants_d    = perf_grants_q;
        perf_conflicts_d = perf_conflicts_q;
        if (grant_any_s && (perf_grants_q != 32'hFFFF_FFFF)) begin
            perf_grants_d = perf_grants_q + 32'd1;
        end else begin
            perf_grants_d = perf_grants_q;
        end
        if (!flush && (count_ones(req_valid) >= 4'd2) && (perf_conflicts_q != 32'hFFFF_FFFF)) begin
            perf_conflicts_d = perf_conflicts_q + 32'd1;
        end else begin
            perf_conflicts_d = perf_conflicts_q;
        end
    end
`endif

    // State registers with synchronous reset that overrides flush and grants
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= {PTR_W{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_grant_q <= {NUM_REQ{1'b0}};
            cdb_tag_q   <= {TAG_W{1'b0}};
            cdb_data_q  <= {DATA_W{1'b0}};
            cdb_rs1_q   <= {DATA_W{1'b0}};
            cdb_rs2_q   <= {DATA_W{1'b0}};
`ifdef CDB_ARB_PERF_EN
            perf_grants_q    <= 32'd0;
            perf_conflicts_q <= 32'd0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_grant_q <= cdb_grant_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_rs1_q   <= cdb_rs1_d;
            cdb_rs2_q   <= cdb_rs2_d;
`ifdef CDB_ARB_PERF_EN
            perf_grants_q    <= perf_grants_d;
            perf_conflicts_q <= perf_conflicts_d;
`endif
        end
    end

    assign req_ready    = req_ready_s;
    assign cdb_valid    = cdb_valid_q;
    assign cdb_latch_en = cdb_valid_q;
    assign cdb_grant    = cdb_grant_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign cdb_rs1_data = cdb_rs1_q;
    assign cdb_rs2_data = cdb_rs2_q;
`ifdef CDB_ARB_PERF_EN
    assign perf_grants    = perf_grants_q;
    assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and sequencer for the common data bus (CDB) in the Tomasulo out-of-order core. Up to NUM_REQ functional units (ALU, branch, multiplier, load/store) compete to broadcast a result each cycle. The block grants exactly one requester per cycle and registers the winning result onto the CDB. It drives the enable that loads the CDB value into the `cdb_latch` and is snooped by reservation stations and the ROB.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8)
- TAG_W, 3, ROB tag width
- DATA_W, 32, result/operand width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- flush  in  1  pipeline squash; suppresses grants this cycle
- req_valid  in  NUM_REQ  per-unit result pending
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as valid
- req_tag  in  NUM_REQ*TAG_W  packed ROB tags, unit i at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  packed results
- req_rs1_data  in  NUM_REQ*DATA_W  packed rs1 operand echo
- req_rs2_data  in  NUM_REQ*DATA_W  packed rs2 operand echo
- cdb_valid  out  1  registered broadcast valid
- cdb_latch_en  out  1  enable to `cdb_latch`; equals cdb_valid
- cdb_grant  out  NUM_REQ  registered one-hot of source unit
- cdb_tag  out  TAG_W  registered tag
- cdb_data, cdb_rs1_data, cdb_rs2_data  out  DATA_W each  registered payload

## Operation
- Handshake:
  - The requester asserts req_valid and holds tag and payload stable until req_valid && req_ready.
  - Transfer happens on that edge.
  - The requester may drop valid only after transfer.
- Arbitration:
  - rr_ptr is a $clog2(NUM_REQ)-bit pointer.
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ; grant the first index with req_valid=1.
  - At most one req_ready bit is high per cycle.
- Pointer update:
  - On a grant to unit i, rr_ptr <= (i+1) mod NUM_REQ. For non-power-of-2 NUM_REQ, wrap explicitly from NUM_REQ-1 to 0.
  - With no grant, rr_ptr holds.
- Output register:
  - On a grant, cdb_valid<=1, cdb_grant<=onehot(i), and tag/data/rs1/rs2 <= unit i's fields.
  - With no grant, cdb_valid<=0, cdb_grant<=0, and payload fields hold their previous values.
- Flush:
  - While flush=1, req_ready=0, no grant, rr_ptr holds, and cdb_valid<=0 at the edge.
  - A broadcast already registered (visible during the flush cycle) is not retracted; consumers squash it themselves.
- Reset:
  - While rst=1, req_ready=0.
  - At the edge: rr_ptr=0, cdb_valid=0, cdb_latch_en=0, cdb_grant=0, cdb_tag=0, cdb_data=0, cdb_rs1_data=0, cdb_rs2_data=0.
  - rst has priority over flush and grants. Requests pending at reset are dropped, not granted.

## Timing
- Grant latency: 0 cycles; req_ready is combinational from req_valid, rr_ptr, flush and rst.
- Broadcast latency: 1 cycle; a grant at cycle t gives cdb_valid=1 at t+1.
- Throughput: 1 result per cycle. Back-to-back grants to the same unit are allowed when it is the only valid requester.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, absent flush.
- No combinational path from req_* to cdb_* outputs.

## Configuration
- CDB_ARB_PERF_EN defined: adds outputs perf_grants (32 bits) and perf_conflicts (32 bits).
  - perf_grants increments on every grant.
  - perf_conflicts increments on every cycle with ≥2 req_valid bits set and flush=0.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on rst, and are not cleared by flush.
- CDB_ARB_PERF_EN not defined: the ports and counters are absent; arbitration is identical.

## Test plan
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 → req_ready=4'b0000, all cdb_* outputs 0. First cycle after release grants unit 0 (req_ready=4'b0001).
- Single requester: at cycle t, req_valid=4'b0100, tag=5, data=32'hDEADBEEF → req_ready=4'b0100 at t. At t+1: cdb_valid=1, cdb_latch_en=1, cdb_grant=4'b0100, cdb_tag=5, cdb_data=32'hDEADBEEF. rr_ptr=3.
- Saturation: req_valid=4'b1111 for 8 cycles from rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; cdb_valid high for 8 consecutive cycles.
- Wrap: rr_ptr=3, req_valid=4'b0011 held → grants unit 0, then unit 1, then unit 0.
- Flush: req_valid=4'b1111, rr_ptr=2, flush=1 for one cycle → req_ready=4'b0000, cdb_valid=0 next cycle. The following cycle grants unit 2.
- Perf (macro defined): req_valid=4'b1111 for 10 cycles after reset → perf_grants=10, perf_conflicts=10. Then req_valid=4'b0001 for 3 cycles → perf_grants=13, perf_conflicts=10.
